// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies a block of words from src to dst via a single-word CPU request port.
// Define MEM_COPY_FILL_EN to add a pattern-fill mode (fill/fill_pattern ports) that skips all reads.
module mem_copy_engine #(
  parameter int DATA_BITS      = 32,
  parameter int WORD_ADDR_BITS = 30,
  parameter int LEN_BITS       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WORD_ADDR_BITS-1:0] src_addr,
  input  logic [WORD_ADDR_BITS-1:0] dst_addr,
  input  logic [LEN_BITS-1:0]       len,
`ifdef MEM_COPY_FILL_EN
  input  logic                      fill,
  input  logic [DATA_BITS-1:0]      fill_pattern,
`endif
  output logic                      busy,
  output logic                      done,
  output logic [LEN_BITS-1:0]       words_done,
  output logic                      mem_req_val,
  input  logic                      mem_req_rdy,
  output logic [WORD_ADDR_BITS-1:0] mem_req_addr,
  output logic [DATA_BITS-1:0]      mem_req_data,
  output logic [3:0]                mem_req_write,
  input  logic                      mem_resp_val,
  input  logic [DATA_BITS-1:0]      mem_resp_data
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;

  state_t                    state;
  logic [WORD_ADDR_BITS-1:0] src_q;
  logic [WORD_ADDR_BITS-1:0] dst_q;
  logic [LEN_BITS-1:0]       len_q;
  logic [LEN_BITS-1:0]       idx;
  logic                      fill_q;

  logic                      fill_sel;
  logic [DATA_BITS-1:0]      fill_data;
  logic [LEN_BITS-1:0]       idx_nxt;
  logic [WORD_ADDR_BITS-1:0] idx_w;
  logic [WORD_ADDR_BITS-1:0] idx_nxt_w;

`ifdef MEM_COPY_FILL_EN
  assign fill_sel  = fill;
  assign fill_data = fill_pattern;
`else
  assign fill_sel  = 1'b0;
  assign fill_data = '0;
`endif

  assign idx_nxt   = idx + 1'b1;
  assign idx_w     = WORD_ADDR_BITS'(idx);
  assign idx_nxt_w = WORD_ADDR_BITS'(idx_nxt);

  // mem_req_data doubles as the read-data holding register between RD_WAIT and WR_REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      idx           <= '0;
      fill_q        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      words_done    <= '0;
      mem_req_val   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      mem_req_write <= 4'h0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_q      <= src_addr;
            dst_q      <= dst_addr;
            len_q      <= len;
            idx        <= '0;
            words_done <= '0;
            fill_q     <= fill_sel;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (fill_sel) begin
              state         <= WR_REQ;
              busy          <= 1'b1;
              mem_req_val   <= 1'b1;
              mem_req_write <= 4'hF;
              mem_req_addr  <= dst_addr;
              mem_req_data  <= fill_data;
            end else begin
              state         <= RD_REQ;
              busy          <= 1'b1;
              mem_req_val   <= 1'b1;
              mem_req_write <= 4'h0;
              mem_req_addr  <= src_addr;
            end
          end
        end
        RD_REQ: begin
          if (mem_req_rdy) begin
            state       <= RD_WAIT;
            mem_req_val <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (mem_resp_val) begin
            state         <= WR_REQ;
            mem_req_data  <= mem_resp_data;
            mem_req_val   <= 1'b1;
            mem_req_write <= 4'hF;
            mem_req_addr  <= dst_q + idx_w;
          end
        end
        WR_REQ: begin
          if (mem_req_rdy) begin
            idx        <= idx_nxt;
            words_done <= words_done + 1'b1;
            if (idx_nxt == len_q) begin
              state         <= DONE;
              done          <= 1'b1;
              busy          <= 1'b0;
              mem_req_val   <= 1'b0;
              mem_req_write <= 4'h0;
            end else if (fill_q) begin
              mem_req_addr <= dst_q + idx_nxt_w;
            end else begin
              state         <= RD_REQ;
              mem_req_write <= 4'h0;
              mem_req_addr  <= src_q + idx_nxt_w;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          mem_req_val <= 1'b0;
        end
      endcase
    end
  end

endmodule
